// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the load-use / branch hazard controller
package hazard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [4:0] XZR_REG       = 5'd31;
    localparam int         LU_STALL_MIN  = 1;
    localparam int         LU_STALL_MAX  = 3;

endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: combinational load-use hazard detect between ID sources and EX load destination
// Ports:
//   valid_ID               ID holds a real instruction
//   rn_ID, rm_ID           ID source registers
//   rn_used_ID, rm_used_ID source actually read
//   rd_EX                  EX destination register
//   lw_EX                  EX instruction is a load
//   hazard                 ID must wait for the EX load result
module hazard_cmp
    import hazard_pkg::*;
(
    input  logic       valid_ID,
    input  logic [4:0] rn_ID,
    input  logic [4:0] rm_ID,
    input  logic       rn_used_ID,
    input  logic       rm_used_ID,
    input  logic [4:0] rd_EX,
    input  logic       lw_EX,
    output logic       hazard
);

    logic w_rn_hit;
    logic w_rm_hit;

    assign w_rn_hit = rn_used_ID && (rn_ID == rd_EX);
    assign w_rm_hit = rm_used_ID && (rm_ID == rd_EX);
    // XZR reads as zero, so a load "into" it never produces a value to wait for
    assign hazard   = valid_ID && lw_EX && (rd_EX != XZR_REG) && (w_rn_hit || w_rm_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall and taken-branch flush control for a 5-stage pipeline
// Parameter LU_STALL_CYCLES (1..3): bubbles inserted per load-use hazard.
// Optional macro HAZ_PERF_CNT_EN adds saturating stall_count / flush_count outputs.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   valid_ID, rn_ID, rm_ID, rn_used_ID, rm_used_ID   ID-stage operand info
//   rd_EX, lw_EX           EX-stage load destination
//   branch_taken_EX        EX resolved a taken branch this cycle
//   pc_hold, if_id_hold    freeze PC and IF/ID
//   if_id_flush            IF/ID loads a NOP
//   id_ex_bubble           ID/EX loads all-zero controls
//   stall_count, flush_count   (HAZ_PERF_CNT_EN only) event counters
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_ID,
    input  logic [4:0] rn_ID,
    input  logic [4:0] rm_ID,
    input  logic       rn_used_ID,
    input  logic       rm_used_ID,
    input  logic [4:0] rd_EX,
    input  logic       lw_EX,
    input  logic       branch_taken_EX,
    output logic       pc_hold,
    output logic       if_id_hold,
    output logic       if_id_flush,
    output logic       id_ex_bubble
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    if (LU_STALL_CYCLES < LU_STALL_MIN || LU_STALL_CYCLES > LU_STALL_MAX) begin : g_bad_param
        $error("LU_STALL_CYCLES out of range");
    end

    // the first bubble is issued from RUN, so STALL only covers the remainder
    localparam logic [1:0] STALL_INIT = 2'(LU_STALL_CYCLES - 1);

    state_t     r_state;
    logic [1:0] r_cnt;
    logic       w_hazard;
    logic       w_run;
    logic       w_stall;
    logic       w_flush;

    hazard_cmp u_cmp (
        .valid_ID   (valid_ID),
        .rn_ID      (rn_ID),
        .rm_ID      (rm_ID),
        .rn_used_ID (rn_used_ID),
        .rm_used_ID (rm_used_ID),
        .rd_EX      (rd_EX),
        .lw_EX      (lw_EX),
        .hazard     (w_hazard)
    );

    // a taken branch kills the held ID instruction anyway, so it overrides any stall
    assign w_run        = !reset && !branch_taken_EX;
    assign w_stall      = w_run && ((r_state == STALL) || w_hazard);
    assign w_flush      = !reset && branch_taken_EX;
    assign pc_hold      = w_stall;
    assign if_id_hold   = w_stall;
    assign if_id_flush  = w_flush;
    assign id_ex_bubble = w_stall || w_flush;

    always_ff @(posedge clk) begin
        if (reset || branch_taken_EX) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
        end else if (r_state == STALL) begin
            r_cnt   <= r_cnt - 2'd1;
            r_state <= (r_cnt == 2'd1) ? RUN : STALL;
        end else if (w_hazard && STALL_INIT != 2'd0) begin
            r_state <= STALL;
            r_cnt   <= STALL_INIT;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl at LU_STALL_CYCLES=1 and 3
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_ID = 1'b0;
    logic [4:0] rn_ID = '0;
    logic [4:0] rm_ID = '0;
    logic       rn_used_ID = 1'b0;
    logic       rm_used_ID = 1'b0;
    logic [4:0] rd_EX = '0;
    logic       lw_EX = 1'b0;
    logic       br = 1'b0;
    logic       pc1, ih1, fl1, bb1;
    logic       pc3, ih3, fl3, bb3;
    int         total = 0;
    int         bad = 0;
    int         rem1 = 0;
    int         rem3 = 0;
    logic [3:0] q1[$];
    logic [3:0] q3[$];
    string      qt[$];
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] sc1, fc1, sc3, fc3;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LU_STALL_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .valid_ID(valid_ID), .rn_ID(rn_ID), .rm_ID(rm_ID),
        .rn_used_ID(rn_used_ID), .rm_used_ID(rm_used_ID), .rd_EX(rd_EX), .lw_EX(lw_EX),
        .branch_taken_EX(br), .pc_hold(pc1), .if_id_hold(ih1), .if_id_flush(fl1),
        .id_ex_bubble(bb1)
`ifdef HAZ_PERF_CNT_EN
        , .stall_count(sc1), .flush_count(fc1)
`endif
    );

    pipe_hazard_ctrl #(.LU_STALL_CYCLES(3)) u3 (
        .clk(clk), .reset(reset), .valid_ID(valid_ID), .rn_ID(rn_ID), .rm_ID(rm_ID),
        .rn_used_ID(rn_used_ID), .rm_used_ID(rm_used_ID), .rd_EX(rd_EX), .lw_EX(lw_EX),
        .branch_taken_EX(br), .pc_hold(pc3), .if_id_hold(ih3), .if_id_flush(fl3),
        .id_ex_bubble(bb3)
`ifdef HAZ_PERF_CNT_EN
        , .stall_count(sc3), .flush_count(fc3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic m_haz();
        return valid_ID && lw_EX && rd_EX != 5'd31 &&
               ((rn_used_ID && rn_ID == rd_EX) || (rm_used_ID && rm_ID == rd_EX));
    endfunction

    // {pc_hold, if_id_hold, if_id_flush, id_ex_bubble}; rem = bubbles still owed
    function automatic logic [3:0] m_exp(input int rem);
        if (reset) return 4'b0000;
        if (br) return 4'b0011;
        if (rem > 0 || m_haz()) return 4'b1101;
        return 4'b0000;
    endfunction

    function automatic int m_next(input int rem, input int n);
        if (reset || br) return 0;
        if (rem > 0) return rem - 1;
        if (m_haz()) return n - 1;
        return 0;
    endfunction

    task automatic step(input string tag, input logic r, input logic v,
                        input logic [4:0] rn, input logic rnu, input logic [4:0] rm,
                        input logic rmu, input logic [4:0] rd, input logic lw, input logic b);
        reset = r; valid_ID = v; rn_ID = rn; rn_used_ID = rnu; rm_ID = rm;
        rm_used_ID = rmu; rd_EX = rd; lw_EX = lw; br = b;
        q1.push_back(m_exp(rem1));
        q3.push_back(m_exp(rem3));
        qt.push_back(tag);
        @(posedge clk);
        rem1 = m_next(rem1, 1);
        rem3 = m_next(rem3, 3);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (qt.size() > 0) begin
            string t;
            t = qt.pop_front();
            chk({t, "_n1"}, {28'd0, pc1, ih1, fl1, bb1}, {28'd0, q1.pop_front()});
            chk({t, "_n3"}, {28'd0, pc3, ih3, fl3, bb3}, {28'd0, q3.pop_front()});
            chk({t, "_nohf1"}, {31'd0, ih1 & fl1}, 32'd0);
            chk({t, "_nohf3"}, {31'd0, ih3 & fl3}, 32'd0);
        end
    end

    function automatic logic [4:0] rreg();
        int k;
        k = $urandom_range(0, 4);
        return (k == 4) ? 5'd31 : 5'(k);
    endfunction

    initial begin
        @(posedge clk);
        #1;
        step("rst0", 1, 1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0);
        step("rst1", 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1);
        step("lu_rn", 0, 1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0);
        idle("lu_a"); idle("lu_b"); idle("lu_c");
        step("xzr", 0, 1, 5'd31, 1, 5'd0, 0, 5'd31, 1, 0);
        step("rm_unused", 0, 1, 5'd0, 1, 5'd5, 0, 5'd5, 1, 0);
        step("not_valid", 0, 0, 5'd5, 1, 5'd5, 1, 5'd5, 1, 0);
        step("not_load", 0, 1, 5'd5, 1, 5'd5, 1, 5'd5, 0, 0);
        step("lu_rm", 0, 1, 5'd1, 1, 5'd7, 1, 5'd7, 1, 0);
        idle("rm_a"); idle("rm_b"); idle("rm_c");
        step("br_haz", 0, 1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0);
        step("br_haz2", 0, 1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1);
        idle("br_haz_a"); idle("br_haz_b");
        step("brk_stall", 0, 1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1);
        step("brk_t1", 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1);
        idle("brk_t2"); idle("brk_t3");
        step("rst_stall", 0, 1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 0);
        step("rst_t1", 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
        idle("rst_t2"); idle("rst_t3");
        step("ign_h", 0, 1, 5'd2, 1, 5'd0, 0, 5'd2, 1, 0);
        step("ign_h1", 0, 1, 5'd2, 1, 5'd0, 0, 5'd2, 1, 0);
        step("ign_h2", 0, 1, 5'd2, 1, 5'd0, 0, 5'd2, 1, 0);
        idle("ign_a"); idle("ign_b"); idle("ign_c");
        for (int i = 0; i < 400; i++) begin
            step("rnd", 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) != 0),
                 rreg(), 1'($urandom_range(0, 1)), rreg(), 1'($urandom_range(0, 1)),
                 rreg(), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0));
        end
`ifdef HAZ_PERF_CNT_EN
        step("pc_rst", 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
        @(negedge clk);
        chk("sc_clr", sc1, 32'd0);
        chk("fc_clr", fc1, 32'd0);
        force u1.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release u1.r_stall_cnt;
        @(posedge clk);
        #1;
        step("pc_h0", 0, 1, 5'd4, 1, 5'd0, 0, 5'd4, 1, 0);
        step("pc_h1", 0, 1, 5'd4, 1, 5'd0, 0, 5'd4, 1, 0);
        step("pc_h2", 0, 1, 5'd4, 1, 5'd0, 0, 5'd4, 1, 0);
        step("pc_br", 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1);
        @(negedge clk);
        chk("sc_sat", sc1, 32'hFFFF_FFFF);
        chk("fc_one", fc1, 32'd1);
`endif
        idle("tail");
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(qt.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter LU_STALL_CYCLES, default 1, legal 1..3: number of bubble cycles inserted per load-use hazard.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 valid_ID  input  1  ID stage holds a real instruction.
REQ-005 rn_ID, rm_ID  input  5 each  ID-stage source register numbers.
REQ-006 rn_used_ID, rm_used_ID  input  1 each  corresponding source is actually read.
REQ-007 rd_EX  input  5  EX-stage destination register.
REQ-008 lw_EX  input  1  EX-stage instruction is a load.
REQ-009 branch_taken_EX  input  1  EX stage resolved a taken branch/CBZ/CBNZ this cycle.
REQ-010 pc_hold  output  1  PC keeps its value.
REQ-011 if_id_hold  output  1  IF/ID register keeps its value.
REQ-012 if_id_flush  output  1  IF/ID register loads a NOP.
REQ-013 id_ex_bubble  output  1  ID/EX register loads all-zero controls (no SW/LW/branch/SetFlag, Dsel zero).

Function
REQ-014 Hazard term h = valid_ID & lw_EX & (rd_EX != 31) & ((rn_used_ID & rn_ID==rd_EX) | (rm_used_ID & rm_ID==rd_EX)); register 31 (XZR) never causes a hazard.
REQ-015 FSM states RUN and STALL; 2-bit down-counter cnt; outputs combinational from state, cnt and inputs.
REQ-016 RUN, branch_taken_EX=1: if_id_flush=1, id_ex_bubble=1, pc_hold=0, if_id_hold=0; stay RUN.
REQ-017 RUN, branch_taken_EX=0, h=1: pc_hold=1, if_id_hold=1, id_ex_bubble=1 (stall cycle 1); if LU_STALL_CYCLES>1 go STALL with cnt=LU_STALL_CYCLES-1, else stay RUN.
REQ-018 RUN, no branch, h=0: all outputs 0.
REQ-019 STALL: pc_hold=1, if_id_hold=1, id_ex_bubble=1; cnt decrements; return to RUN on the cycle cnt==1; h ignored.
REQ-020 Branch has priority: branch_taken_EX=1 in any state gives REQ-016 outputs, forces RUN, clears cnt; hold outputs 0 that cycle.
REQ-021 if_id_hold and if_id_flush never asserted in the same cycle.
REQ-022 Total bubbles per isolated load-use hazard = exactly LU_STALL_CYCLES.

Reset
REQ-023 While reset=1: all outputs 0, next state RUN, cnt=0; reset mid-STALL aborts the stall.
REQ-024 First cycle after reset deasserts behaves as RUN with cleared history.

Configuration
REQ-025 HAZ_PERF_CNT_EN defined: adds outputs stall_count[31:0] (+1 per cycle with id_ex_bubble=1 due to load-use) and flush_count[31:0] (+1 per branch_taken_EX cycle); both saturate at 32'hFFFFFFFF and clear on reset.
REQ-026 HAZ_PERF_CNT_EN undefined: ports and counters absent; remaining behaviour identical.

Structure
REQ-027 Shared package hazard_pkg: state enum (RUN, STALL), constant XZR_REG=5'd31, LU_STALL_CYCLES legal-range constants.
REQ-028 Sub-module hazard_cmp: combinational REQ-014 compare, instantiated once.

Verification
REQ-029 LU_STALL_CYCLES=1, lw_EX=1, rd_EX=5, rn_ID=5, rn_used_ID=1, valid_ID=1 -> one cycle pc_hold=if_id_hold=id_ex_bubble=1, then 0.
REQ-030 Same with rd_EX=31, rn_ID=31 -> no stall; with rm_ID=5, rm_used_ID=0 -> no stall.
REQ-031 LU_STALL_CYCLES=3, hazard at cycle t -> bubble at t, t+1, t+2; all 0 at t+3.
REQ-032 LU_STALL_CYCLES=3, hazard at t, branch_taken_EX=1 at t+1 -> t+1 flush+bubble, no hold; RUN at t+2.
REQ-033 reset=1 at t+1 of a 3-cycle stall -> outputs 0 at t+1, RUN at t+2, no residual bubble.
REQ-034 HAZ_PERF_CNT_EN, counters preloaded near max via 2^32 events or force -> stall_count holds 32'hFFFFFFFF, no wrap.
